// File: rtl/axi_w_stream_tap.sv
// AXI W-channel tap: forwards W beats unchanged and captures {wdata, wlast} into a FIFO,
// then replays complete bursts on a simple valid/ready stream.
module axi_w_stream_tap #(
    parameter int DATA_WIDTH    = 128,
    parameter int ID_WIDTH      = 32,
    parameter int USER_WIDTH    = 64,
    parameter int BURST_LEN     = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int BLOCK_ON_FULL = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ready,
    output logic                    valid,
    output logic                    in_progress,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    last,
    output logic                    overflow,
    output logic [15:0]             drop_count,
    output logic [ID_WIDTH-1:0]     AXIM_wid,
    output logic [DATA_WIDTH-1:0]   AXIM_wdata,
    output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
    output logic                    AXIM_wlast,
    output logic [USER_WIDTH-1:0]   AXIM_wuser,
    output logic                    AXIM_wvalid,
    input  logic                    AXIM_wready,
    input  logic [ID_WIDTH-1:0]     AXIS_wid,
    input  logic [DATA_WIDTH-1:0]   AXIS_wdata,
    input  logic [DATA_WIDTH/8-1:0] AXIS_wstrb,
    input  logic                    AXIS_wlast,
    input  logic [USER_WIDTH-1:0]   AXIS_wuser,
    input  logic                    AXIS_wvalid,
    output logic                    AXIS_wready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, prev_ptr_s;
    logic [CW-1:0]          count_q, count_d, burst_cnt_q, burst_cnt_d, free_s;
    logic                   in_burst_q, in_burst_d, drop_q, drop_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0]    head_s;
    logic                   full_s, stall_n_s, beat_acc_s, dropping_s;
    logic                   push_s, pop_s, retro_s, ovf_set_s, drop_inc_s;
    logic                   burst_inc_s, burst_dec_s;

    assign AXIM_wid    = AXIS_wid;
    assign AXIM_wdata  = AXIS_wdata;
    assign AXIM_wstrb  = AXIS_wstrb;
    assign AXIM_wlast  = AXIS_wlast;
    assign AXIM_wuser  = AXIS_wuser;

    // Full is judged on registered occupancy only, so a same-cycle pop never relieves it.
    assign full_s      = (count_q == CW'(FIFO_DEPTH));
    assign free_s      = CW'(FIFO_DEPTH) - count_q;
    assign stall_n_s   = (BLOCK_ON_FULL != 0) ? ~full_s : 1'b1;
    assign AXIM_wvalid = AXIS_wvalid & resetn & stall_n_s;
    assign AXIS_wready = AXIM_wready & resetn & stall_n_s;
    assign beat_acc_s  = AXIS_wvalid & AXIS_wready;

    assign head_s      = mem_q[rd_ptr_q];
    assign prev_ptr_s  = wr_ptr_q - AW'(1);
    assign data        = head_s[DATA_WIDTH:1];
    assign last        = resetn & (count_q != CW'(0)) & head_s[0];
    assign valid       = (burst_cnt_q != CW'(0));
    assign in_progress = (state_q == ST_STREAM);
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

    // Capture admission, drop bookkeeping and the stream FSM.
    always_comb begin
        dropping_s  = 1'b0;
        push_s      = 1'b0;
        retro_s     = 1'b0;
        ovf_set_s   = 1'b0;
        drop_inc_s  = 1'b0;
        pop_s       = (state_q == ST_STREAM) & ready & (count_q != CW'(0));

        if (BLOCK_ON_FULL != 0) begin
            push_s = beat_acc_s;
        end else begin
            dropping_s = in_burst_q ? drop_q : (free_s < CW'(BURST_LEN));
            if (beat_acc_s) begin
                if (dropping_s) begin
                    ovf_set_s  = 1'b1;
                    drop_inc_s = ~in_burst_q;
                end else if (full_s) begin
                    // Over-long burst hit a full FIFO: keep framing by tagging the last stored beat.
                    ovf_set_s  = 1'b1;
                    retro_s    = AXIS_wlast;
                end else begin
                    push_s     = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
        end

        in_burst_d = in_burst_q;
        drop_d     = drop_q;
        if (beat_acc_s) begin
            in_burst_d = ~AXIS_wlast;
            drop_d     = dropping_s & ~AXIS_wlast;
        end else begin
            in_burst_d = in_burst_q;
        end

        drop_count_d = drop_count_q;
        if (drop_inc_s && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
        overflow_d = overflow_q | ovf_set_s;

        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(pop_s);

        burst_inc_s = (push_s & AXIS_wlast) | retro_s;
        burst_dec_s = pop_s & head_s[0];
        if (burst_inc_s && !burst_dec_s) begin
            burst_cnt_d = burst_cnt_q + CW'(1);
        end else if (burst_dec_s && !burst_inc_s) begin
            burst_cnt_d = burst_cnt_q - CW'(1);
        end else begin
            burst_cnt_d = burst_cnt_q;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = (valid && ready) ? ST_STREAM : ST_IDLE;
            ST_STREAM: state_d = (pop_s && head_s[0]) ? ST_IDLE : ST_STREAM;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= AW'(0);
            rd_ptr_q     <= AW'(0);
            count_q      <= CW'(0);
            burst_cnt_q  <= CW'(0);
            in_burst_q   <= 1'b0;
            drop_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            burst_cnt_q  <= burst_cnt_d;
            in_burst_q   <= in_burst_d;
            drop_q       <= drop_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // FIFO storage; contents are qualified by occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {AXIS_wdata, AXIS_wlast};
        end else if (retro_s) begin
            mem_q[prev_ptr_s][0] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_w_stream_tap.sv
// Scoreboard bench for axi_w_stream_tap: one blocking and one dropping instance,
// expectations queued at stimulus time and checked by negedge monitors.
module tb_axi_w_stream_tap;
    typedef struct packed {
        logic [31:0]  id;
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
        logic [63:0]  user;
    } beat_t;

    logic         clk = 1'b0, resetn = 1'b0;
    logic [31:0]  s_id = '0;
    logic [127:0] s_data = '0;
    logic [15:0]  s_strb = '0;
    logic         s_last = 1'b0;
    logic [63:0]  s_user = '0;
    logic         s_valid = 1'b0, sel = 1'b0, m_ready = 1'b1;
    logic         rdy_b = 1'b0, rdy_d = 1'b0;
    logic         s_valid_b, s_valid_d;

    logic         b_valid, b_inprog, b_last, b_ovf, b_mlast, b_mvalid, b_swready;
    logic [127:0] b_data, b_mdata;
    logic [15:0]  b_dcnt, b_mstrb;
    logic [31:0]  b_mid;
    logic [63:0]  b_muser;
    logic         d_valid, d_inprog, d_last, d_ovf, d_mlast, d_mvalid, d_swready;
    logic [127:0] d_data, d_mdata;
    logic [15:0]  d_dcnt, d_mstrb;
    logic [31:0]  d_mid;
    logic [63:0]  d_muser;

    beat_t qm_b[$], qs_b[$], qm_d[$], qs_d[$];
    int n_tests = 0, n_fail = 0;

    assign s_valid_b = s_valid & ~sel;
    assign s_valid_d = s_valid & sel;

    always #5 clk = ~clk;

    axi_w_stream_tap #(.BLOCK_ON_FULL(1)) u_blk (
        .clk(clk), .resetn(resetn), .ready(rdy_b), .valid(b_valid), .in_progress(b_inprog),
        .data(b_data), .last(b_last), .overflow(b_ovf), .drop_count(b_dcnt),
        .AXIM_wid(b_mid), .AXIM_wdata(b_mdata), .AXIM_wstrb(b_mstrb), .AXIM_wlast(b_mlast),
        .AXIM_wuser(b_muser), .AXIM_wvalid(b_mvalid), .AXIM_wready(m_ready),
        .AXIS_wid(s_id), .AXIS_wdata(s_data), .AXIS_wstrb(s_strb), .AXIS_wlast(s_last),
        .AXIS_wuser(s_user), .AXIS_wvalid(s_valid_b), .AXIS_wready(b_swready));

    axi_w_stream_tap #(.BLOCK_ON_FULL(0)) u_drp (
        .clk(clk), .resetn(resetn), .ready(rdy_d), .valid(d_valid), .in_progress(d_inprog),
        .data(d_data), .last(d_last), .overflow(d_ovf), .drop_count(d_dcnt),
        .AXIM_wid(d_mid), .AXIM_wdata(d_mdata), .AXIM_wstrb(d_mstrb), .AXIM_wlast(d_mlast),
        .AXIM_wuser(d_muser), .AXIM_wvalid(d_mvalid), .AXIM_wready(m_ready),
        .AXIS_wid(s_id), .AXIS_wdata(s_data), .AXIS_wstrb(s_strb), .AXIS_wlast(s_last),
        .AXIS_wuser(s_user), .AXIS_wvalid(s_valid_d), .AXIS_wready(d_swready));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int k, input bit l);
        beat_t b;
        b.id   = 32'h1000_0000 + 32'(k);
        b.data = {4{32'hC0DE_0000 + 32'(k)}};
        b.strb = 16'hA5A5 ^ 16'(k);
        b.last = l;
        b.user = {32'h5500_0000 + 32'(k), ~32'(k)};
        return b;
    endfunction

    // Stream-side and W-master-side monitors for both instances.
    always @(negedge clk) begin
        beat_t e;
        if (resetn) begin
            if (b_inprog && rdy_b) begin
                if (qs_b.size() == 0) chk("b_unexpected_pop", 1'b1, 1'b0);
                else begin
                    e = qs_b.pop_front();
                    chk("b_stream_data", b_data, e.data);
                    chk("b_stream_last", b_last, e.last);
                end
            end
            if (d_inprog && rdy_d) begin
                if (qs_d.size() == 0) chk("d_unexpected_pop", 1'b1, 1'b0);
                else begin
                    e = qs_d.pop_front();
                    chk("d_stream_data", d_data, e.data);
                    chk("d_stream_last", d_last, e.last);
                end
            end
            if (b_mvalid && m_ready) begin
                if (qm_b.size() == 0) chk("b_unexpected_axim", 1'b1, 1'b0);
                else begin
                    e = qm_b.pop_front();
                    chk("b_axim_beat", {b_mid, b_mdata, b_mstrb, b_mlast, b_muser}, e);
                end
            end
            if (d_mvalid && m_ready) begin
                if (qm_d.size() == 0) chk("d_unexpected_axim", 1'b1, 1'b0);
                else begin
                    e = qm_d.pop_front();
                    chk("d_axim_beat", {d_mid, d_mdata, d_mstrb, d_mlast, d_muser}, e);
                end
            end
        end
    end

    task automatic drive(input bit d, input beat_t bt, input bit store);
        if (d) begin
            qm_d.push_back(bt);
            if (store) qs_d.push_back(bt);
        end else begin
            qm_b.push_back(bt);
            if (store) qs_b.push_back(bt);
        end
        sel = d; s_id = bt.id; s_data = bt.data; s_strb = bt.strb; s_last = bt.last; s_user = bt.user;
        s_valid = 1'b1;
    endtask

    task automatic wait_hs(input bit d);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (d ? d_swready : b_swready) break;
            n++;
            if (n > 200) begin
                chk("handshake_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send(input bit d, input beat_t bt, input bit store);
        drive(d, bt, store);
        wait_hs(d);
    endtask

    task automatic drain(input bit d);
        int n = 0;
        while ((d ? (d_valid || d_inprog) : (b_valid || b_inprog)) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", (n < 300), 1'b1);
        #1;
    endtask

    initial begin
        // Reset state, with W inputs active so the resetn gating is exercised.
        s_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_valid", b_valid, 1'b0);
        chk("rst_b_inprog", b_inprog, 1'b0);
        chk("rst_b_last", b_last, 1'b0);
        chk("rst_b_ovf", b_ovf, 1'b0);
        chk("rst_b_dcnt", b_dcnt, 16'd0);
        chk("rst_b_mvalid", b_mvalid, 1'b0);
        chk("rst_b_swready", b_swready, 1'b0);
        chk("rst_d_mvalid", d_mvalid, 1'b0);
        chk("rst_d_dcnt", d_dcnt, 16'd0);
        s_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;

        // 4-beat burst, streamed straight through.
        rdy_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(1'b0, mk(k, k == 3), 1'b1);
            if (k == 2) chk("valid_before_last", b_valid, 1'b0);
            if (k == 3) chk("valid_after_last", b_valid, 1'b1);
        end
        drain(1'b0);
        chk("b_idle_after_4", b_valid, 1'b0);

        // Blocking: two 8-beat bursts fill the FIFO, third burst stalls until a pop.
        rdy_b = 1'b0;
        for (int k = 0; k < 16; k++) send(1'b0, mk(100 + k, (k % 8) == 7), 1'b1);
        drive(1'b0, mk(116, 1'b0), 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("blk_stall_full", b_swready, 1'b0);
        end
        @(posedge clk);
        #1 rdy_b = 1'b1;
        @(negedge clk);
        chk("blk_stall_idle", b_swready, 1'b0);
        @(negedge clk);
        chk("blk_stall_pop_cycle", b_swready, 1'b0);
        chk("blk_streaming", b_inprog, 1'b1);
        wait_hs(1'b0);
        for (int k = 1; k < 8; k++) send(1'b0, mk(116 + k, k == 7), 1'b1);
        drain(1'b0);

        // Simultaneous push of a last beat and pop of a last beat.
        rdy_b = 1'b0;
        send(1'b0, mk(200, 1'b1), 1'b1);
        @(posedge clk);
        #1 rdy_b = 1'b1;
        @(posedge clk);
        #1 drive(1'b0, mk(201, 1'b1), 1'b1);
        wait_hs(1'b0);
        chk("simul_valid", b_valid, 1'b1);
        chk("simul_back_to_idle", b_inprog, 1'b0);
        drain(1'b0);

        // 20 single-beat bursts through a depth-16 FIFO.
        for (int k = 0; k < 20; k++) send(1'b0, mk(300 + k, 1'b1), 1'b1);
        drain(1'b0);
        chk("b_ovf_never", b_ovf, 1'b0);

        // Drop mode: 9 entries buffered, a new 8-beat burst is forwarded but dropped.
        rdy_d = 1'b0;
        for (int k = 0; k < 8; k++) send(1'b1, mk(400 + k, k == 7), 1'b1);
        send(1'b1, mk(408, 1'b1), 1'b1);
        chk("d_ovf_before", d_ovf, 1'b0);
        for (int k = 0; k < 8; k++) send(1'b1, mk(410 + k, k == 7), 1'b0);
        chk("d_drop_count", d_dcnt, 16'd1);
        chk("d_overflow", d_ovf, 1'b1);
        chk("d_valid_kept", d_valid, 1'b1);
        rdy_d = 1'b1;
        drain(1'b1);
        chk("d_all_streamed", qs_d.size(), 0);
        chk("d_ovf_sticky", d_ovf, 1'b1);

        // Asynchronous reset in the middle of a stream.
        rdy_d = 1'b0;
        for (int k = 0; k < 4; k++) send(1'b1, mk(500 + k, k == 3), 1'b1);
        rdy_d = 1'b1;
        begin
            int n = 0;
            while (!d_inprog && n < 50) begin
                @(posedge clk);
                n++;
            end
            chk("d_enter_stream", d_inprog, 1'b1);
        end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_inprog", d_inprog, 1'b0);
        chk("arst_valid", d_valid, 1'b0);
        chk("arst_dcnt", d_dcnt, 16'd0);
        chk("arst_ovf", d_ovf, 1'b0);
        chk("arst_last", d_last, 1'b0);
        qs_d.delete();
        rdy_d = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("post_rst_valid", d_valid, 1'b0);

        chk("qs_b_empty", qs_b.size(), 0);
        chk("qm_b_empty", qm_b.size(), 0);
        chk("qm_d_empty", qm_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
